crc_serial_checker: RTL and testbench
=====================================

// Module: crc_serial_checker
// PURPOSE
//  Parametrised serial CRC accumulator/checker for the USB receive path. Consumes the
//  destuffed NRZI-decoded bit stream one bit per enabled clock, tracks packet framing,
//  and on end-of-packet compares the register to the polynomial's good-residue constant.
//  One instance per CRC type (CRC16 for DATA packets, CRC5 for tokens) replaces the fixed crc_16_checker.
// PARAMETERS
//  CRC_W   16       CRC register width (5..32)
//  POLY    16'h8005 generator polynomial, x^CRC_W term implied
//  INIT    16'hFFFF register value at start of every packet
//  RESIDUE 16'h800D register value after a correct payload plus CRC field has been shifted in
//  CNT_W   12       width of bit counter (saturating)
// PORTS
//  clk          in   1      system clock, rising edge
//  n_rst        in   1      asynchronous active-low reset
//  clear        in   1      sync: abort current packet, reinitialise to IDLE
//  shift_enable in   1      serial_in is valid this cycle
//  serial_in    in   1      data bit, transmission order (LSB of each byte first)
//  eop          in   1      end of packet; bit on serial_in this cycle is last if shift_enable=1
//  crc_out      out  CRC_W  live CRC register
//  bit_count    out  CNT_W  bits shifted in current/last packet, saturates at all-ones
//  busy         out  1      state == ACCUM
//  done         out  1      one-cycle pulse: check result valid
//  crc_ok       out  1      last packet ended with crc_out==RESIDUE and bit_count>=CRC_W; held
//  crc_err      out  1      last packet failed (residue mismatch or too short); held
// BEHAVIOUR
//  Reset (n_rst=0, async): state=IDLE, crc_out=INIT, bit_count=0, done=crc_ok=crc_err=0.
//  Shift step: fb = serial_in ^ crc[CRC_W-1]; crc_next = {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
//  States: IDLE, ACCUM, DONE (registered, 2-bit). Priority per cycle: clear > eop > shift_enable.
//  IDLE : crc=INIT, count=0. shift_enable -> apply shift step from INIT, count=1, go ACCUM.
//         shift_enable&eop together -> single-bit packet, go DONE, result = err (too short).
//         eop alone -> go DONE, done pulse, crc_err=1 (empty packet).
//  ACCUM: shift_enable -> shift step, count+1 (saturate). eop -> evaluate using crc_next and
//         count_next when shift_enable=1 in same cycle, else current values; go DONE.
//  DONE : crc_out, bit_count, crc_ok/crc_err held. shift_enable -> new packet: load INIT, apply
//         shift step, count=1, crc_ok=crc_err=0, go ACCUM. eop alone ignored.
//  clear (any state): next edge crc=INIT, count=0, crc_ok=crc_err=0, done=0, state=IDLE.
//  done is registered: eop sampled at edge N -> done=1, crc_ok/crc_err valid from edge N to
//  N+1; done low from edge N+1. crc_ok and crc_err never both 1; both 0 except in DONE.
//  shift_enable=0 in ACCUM: register and count hold (gaps from bit-stuff removal allowed).
//  Reset mid-packet: immediate return to reset values; no done pulse.
//  All arithmetic masked to CRC_W bits; POLY/INIT/RESIDUE bits above CRC_W ignored.
// TESTING
//  1 Reset: n_rst=0 mid-shift -> crc_out=16'hFFFF, bit_count=0, done/crc_ok/crc_err=0 at once.
//  2 Zero-length DATA packet: 16 zero bits, eop on 16th -> crc_out=16'h800D, bit_count=16,
//    done pulse 1 cycle, crc_ok=1, crc_err=0.
//  3 Corrupt: same as 2 with bit 7 set to 1 -> crc_ok=0, crc_err=1, bit_count=16.
//  4 Gapped stream: scenario 2 with shift_enable low 3 cycles between every bit -> identical
//    result; 32-bit payload 32'h0302A5FE + ref-model CRC16 (complemented, LSB first) -> crc_ok=1.
//  5 Back-to-back / clear: packet 2 then packet 3 starting cycle after done -> second reports
//    crc_err=1; clear asserted after 9 bits of a packet -> IDLE, crc_out=INIT, no done pulse.
//  6 CRC5 instance (CRC_W=5, POLY=5'h05, INIT=5'h1F, RESIDUE=5'h0C): 11 token bits + ref-model
//    CRC5 -> crc_ok=1; eop after 3 bits -> crc_err=1 (too short); eop in IDLE -> crc_err=1.

Source files
------------

// File: rtl/crc_serial_checker.sv
// Parametrised serial CRC accumulator/checker for the USB receive path.
// Shifts one destuffed bit per enabled cycle and checks the good residue at end of packet.
module crc_serial_checker #(
   parameter int unsigned CRC_W   = 16,
   parameter logic [31:0] POLY    = 32'h0000_8005,
   parameter logic [31:0] INIT    = 32'h0000_FFFF,
   parameter logic [31:0] RESIDUE = 32'h0000_800D,
   parameter int unsigned CNT_W   = 12
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             shift_enable,
   input  logic             serial_in,
   input  logic             eop,
   output logic [CRC_W-1:0] crc_out,
   output logic [CNT_W-1:0] bit_count,
   output logic             busy,
   output logic             done,
   output logic             crc_ok,
   output logic             crc_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CRC_W-1:0] POLY_M  = POLY[CRC_W-1:0];
   localparam logic [CRC_W-1:0] INIT_M  = INIT[CRC_W-1:0];
   localparam logic [CRC_W-1:0] RES_M   = RESIDUE[CRC_W-1:0];
   localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(CRC_W);

   state_t           state;
   logic [CRC_W-1:0] crc_base, crc_step, crc_eval;
   logic [CNT_W-1:0] cnt_base, cnt_step, cnt_eval;
   logic             fb, pass;

   // Outside ACCUM a shifted bit always starts a fresh packet from INIT,
   // so IDLE and DONE share one datapath.
   always_comb begin
      crc_base = (state == ACCUM) ? crc_out : INIT_M;
      cnt_base = (state == ACCUM) ? bit_count : '0;
      fb       = serial_in ^ crc_base[CRC_W-1];
      crc_step = {crc_base[CRC_W-2:0], 1'b0} ^ (fb ? POLY_M : '0);
      cnt_step = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
      crc_eval = shift_enable ? crc_step : crc_out;
      cnt_eval = shift_enable ? cnt_step : bit_count;
      pass     = (crc_eval == RES_M) && (cnt_eval >= MIN_LEN);
   end

   assign busy = (state == ACCUM);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         crc_out   <= INIT_M;
         bit_count <= '0;
         done      <= 1'b0;
         crc_ok    <= 1'b0;
         crc_err   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (clear) begin
            state     <= IDLE;
            crc_out   <= INIT_M;
            bit_count <= '0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
         end else if (eop && (state != DONE || shift_enable)) begin
            if (shift_enable) begin
               crc_out   <= crc_step;
               bit_count <= cnt_step;
            end
            state   <= DONE;
            done    <= 1'b1;
            crc_ok  <= pass;
            crc_err <= !pass;
         end else if (shift_enable) begin
            crc_out   <= crc_step;
            bit_count <= cnt_step;
            state     <= ACCUM;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_crc_serial_checker.sv
// Scoreboard bench for crc_serial_checker: CRC16 and CRC5 instances share one stimulus stream.
module tb_crc_serial_checker;

   logic clk = 1'b0, n_rst = 1'b0, clear = 1'b0;
   logic shift_enable = 1'b0, serial_in = 1'b0, eop = 1'b0;

   logic [15:0] crc16;
   logic [11:0] cnt16;
   logic        busy16, done16, ok16, err16;
   logic [4:0]  crc5;
   logic [11:0] cnt5;
   logic        busy5, done5, ok5, err5;

   always #5 clk = ~clk;

   crc_serial_checker #(.CRC_W(16), .POLY(32'h8005), .INIT(32'hFFFF), .RESIDUE(32'h800D), .CNT_W(12)) dut16 (
      .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable), .serial_in(serial_in),
      .eop(eop), .crc_out(crc16), .bit_count(cnt16), .busy(busy16), .done(done16),
      .crc_ok(ok16), .crc_err(err16));

   crc_serial_checker #(.CRC_W(5), .POLY(32'h05), .INIT(32'h1F), .RESIDUE(32'h0C), .CNT_W(12)) dut5 (
      .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable), .serial_in(serial_in),
      .eop(eop), .crc_out(crc5), .bit_count(cnt5), .busy(busy5), .done(done5),
      .crc_ok(ok5), .crc_err(err5));

   typedef struct packed {
      logic        ok;
      logic        err;
      logic [11:0] cnt;
      logic [15:0] crc;
      logic        chk;
   } res_t;

   res_t sb16[$], sb5[$], obs16[$], obs5[$];
   logic pkt[$];
   int   checks = 0, failures = 0, dbl16 = 0, dbl5 = 0;
   logic prev16 = 1'b0, prev5 = 1'b0;
   res_t mon16, mon5;

   // Capture every done pulse; a pulse lasting two samples is counted separately.
   always @(negedge clk) begin
      if (done16 === 1'b1) begin
         mon16 = '{ok: ok16, err: err16, cnt: cnt16, crc: crc16, chk: 1'b0};
         obs16.push_back(mon16);
         if (prev16) dbl16++;
      end
      if (done5 === 1'b1) begin
         mon5 = '{ok: ok5, err: err5, cnt: cnt5, crc: {11'd0, crc5}, chk: 1'b0};
         obs5.push_back(mon5);
         if (prev5) dbl5++;
      end
      prev16 = (done16 === 1'b1);
      prev5  = (done5 === 1'b1);
   end

   initial begin
      #400000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         shift_enable = 1'b0; eop = 1'b0; clear = 1'b0; serial_in = 1'b0;
      end
   endtask

   task automatic send(input int gap, input bit with_eop);
      for (int i = 0; i < pkt.size(); i++) begin
         @(negedge clk);
         shift_enable = 1'b1;
         serial_in    = pkt[i];
         eop          = with_eop && (i == pkt.size() - 1);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            shift_enable = 1'b0; eop = 1'b0;
         end
      end
   endtask

   function automatic void add_bits(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) pkt.push_back(w[i]);
   endfunction

   // Reflected (LSB-first) reference CRCs; field is the complement, sent LSB first.
   function automatic logic [15:0] ref_crc16();
      logic [15:0] r = 16'hFFFF;
      foreach (pkt[i]) r = (r[0] ^ pkt[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      return ~r;
   endfunction

   function automatic logic [4:0] ref_crc5();
      logic [4:0] r = 5'h1F;
      foreach (pkt[i]) r = (r[0] ^ pkt[i]) ? ((r >> 1) ^ 5'h14) : (r >> 1);
      return ~r;
   endfunction

   task automatic pop16(output res_t e, output res_t o, output bit got);
      e = '0; o = '0;
      if (sb16.size() != 0) e = sb16.pop_front();
      got = (obs16.size() != 0);
      if (got) o = obs16.pop_front();
   endtask

   task automatic pop5(output res_t e, output res_t o, output bit got);
      e = '0; o = '0;
      if (sb5.size() != 0) e = sb5.pop_front();
      got = (obs5.size() != 0);
      if (got) o = obs5.pop_front();
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({crc16, cnt16, done16, ok16, err16, busy16} !== {16'hFFFF, 12'd0, 4'b0000}) begin
         failures++;
         $display("FAIL reset16 crc=%h cnt=%0d done=%b ok=%b err=%b busy=%b expected FFFF/0/0/0/0/0",
                  crc16, cnt16, done16, ok16, err16, busy16);
      end
      checks++;
      if ({crc5, cnt5, busy5} !== {5'h1F, 12'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset5 crc=%h cnt=%0d busy=%b expected 1F/0/0", crc5, cnt5, busy5);
      end
      n_rst = 1'b1;
      obs16.delete();
      pkt.delete(); add_bits(32'h0B, 5);
      send(0, 1'b0);
      @(posedge clk); #1;
      checks++;
      if ({cnt16, busy16} !== {12'd5, 1'b1}) begin
         failures++;
         $display("FAIL pre_reset cnt=%0d busy=%b expected 5/1", cnt16, busy16);
      end
      #1 n_rst = 1'b0;
      #1;
      checks++;
      if ({crc16, cnt16, done16, ok16, err16, busy16} !== {16'hFFFF, 12'd0, 4'b0000}) begin
         failures++;
         $display("FAIL async_reset crc=%h cnt=%0d done=%b ok=%b err=%b busy=%b expected FFFF/0/0/0/0/0",
                  crc16, cnt16, done16, ok16, err16, busy16);
      end
      @(negedge clk);
      shift_enable = 1'b0; n_rst = 1'b1;
      idle(3);
      checks++;
      if (obs16.size() != 0) begin
         failures++;
         $display("FAIL reset_no_done pulses=%0d expected 0", obs16.size());
      end
   endtask

   task automatic test_zero_len();
      res_t e, o; bit got;
      idle(2); obs16.delete();
      pkt.delete(); add_bits(32'h0, 16);
      sb16.push_back('{ok: 1'b1, err: 1'b0, cnt: 12'd16, crc: 16'h800D, chk: 1'b1});
      send(0, 1'b1); idle(3);
      pop16(e, o, got);
      checks++;
      if (!got || o.ok !== e.ok || o.err !== e.err || o.cnt !== e.cnt || (e.chk && o.crc !== e.crc)) begin
         failures++;
         $display("FAIL zero_len got=%b ok=%b err=%b cnt=%0d crc=%h expected ok=%b err=%b cnt=%0d crc=%h",
                  got, o.ok, o.err, o.cnt, o.crc, e.ok, e.err, e.cnt, e.crc);
      end
   endtask

   task automatic test_corrupt();
      res_t e, o; bit got;
      idle(2); obs16.delete();
      pkt.delete(); add_bits(32'h80, 16);
      sb16.push_back('{ok: 1'b0, err: 1'b1, cnt: 12'd16, crc: 16'h0, chk: 1'b0});
      send(0, 1'b1); idle(3);
      pop16(e, o, got);
      checks++;
      if (!got || o.ok !== e.ok || o.err !== e.err || o.cnt !== e.cnt || (e.chk && o.crc !== e.crc)) begin
         failures++;
         $display("FAIL corrupt got=%b ok=%b err=%b cnt=%0d expected ok=%b err=%b cnt=%0d",
                  got, o.ok, o.err, o.cnt, e.ok, e.err, e.cnt);
      end
   endtask

   task automatic test_gapped();
      res_t e, o; bit got;
      logic [15:0] f;
      idle(2); obs16.delete();
      pkt.delete(); add_bits(32'h0, 16);
      sb16.push_back('{ok: 1'b1, err: 1'b0, cnt: 12'd16, crc: 16'h800D, chk: 1'b1});
      send(3, 1'b1); idle(3);
      pop16(e, o, got);
      checks++;
      if (!got || o.ok !== e.ok || o.err !== e.err || o.cnt !== e.cnt || (e.chk && o.crc !== e.crc)) begin
         failures++;
         $display("FAIL gapped_zero got=%b ok=%b err=%b cnt=%0d crc=%h expected ok=%b err=%b cnt=%0d crc=%h",
                  got, o.ok, o.err, o.cnt, o.crc, e.ok, e.err, e.cnt, e.crc);
      end
      pkt.delete(); add_bits(32'h0302A5FE, 32);
      f = ref_crc16(); add_bits({16'h0, f}, 16);
      sb16.push_back('{ok: 1'b1, err: 1'b0, cnt: 12'd48, crc: 16'h800D, chk: 1'b1});
      send(3, 1'b1); idle(3);
      pop16(e, o, got);
      checks++;
      if (!got || o.ok !== e.ok || o.err !== e.err || o.cnt !== e.cnt || (e.chk && o.crc !== e.crc)) begin
         failures++;
         $display("FAIL gapped_payload got=%b ok=%b err=%b cnt=%0d crc=%h expected ok=%b err=%b cnt=%0d crc=%h",
                  got, o.ok, o.err, o.cnt, o.crc, e.ok, e.err, e.cnt, e.crc);
      end
   endtask

   task automatic test_back_to_back();
      res_t e, o; bit got;
      idle(2); obs16.delete(); dbl16 = 0;
      sb16.push_back('{ok: 1'b1, err: 1'b0, cnt: 12'd16, crc: 16'h800D, chk: 1'b1});
      sb16.push_back('{ok: 1'b0, err: 1'b1, cnt: 12'd16, crc: 16'h0, chk: 1'b0});
      pkt.delete(); add_bits(32'h0, 16);
      send(0, 1'b1);
      pkt.delete(); add_bits(32'h80, 16);
      send(0, 1'b1);
      idle(3);
      pop16(e, o, got);
      checks++;
      if (!got || o.ok !== e.ok || o.err !== e.err || o.cnt !== e.cnt || (e.chk && o.crc !== e.crc)) begin
         failures++;
         $display("FAIL b2b_first got=%b ok=%b err=%b cnt=%0d crc=%h expected ok=%b err=%b cnt=%0d crc=%h",
                  got, o.ok, o.err, o.cnt, o.crc, e.ok, e.err, e.cnt, e.crc);
      end
      pop16(e, o, got);
      checks++;
      if (!got || o.ok !== e.ok || o.err !== e.err || o.cnt !== e.cnt) begin
         failures++;
         $display("FAIL b2b_second got=%b ok=%b err=%b cnt=%0d expected ok=%b err=%b cnt=%0d",
                  got, o.ok, o.err, o.cnt, e.ok, e.err, e.cnt);
      end
      checks++;
      if (dbl16 != 0) begin
         failures++;
         $display("FAIL done_width long_pulses=%0d expected 0", dbl16);
      end
   endtask

   task automatic test_clear();
      idle(1); obs16.delete();
      pkt.delete(); add_bits(32'h1B5, 9);
      send(0, 1'b0);
      @(negedge clk);
      shift_enable = 1'b0; clear = 1'b1;
      checks++;
      if ({cnt16, busy16} !== {12'd9, 1'b1}) begin
         failures++;
         $display("FAIL pre_clear cnt=%0d busy=%b expected 9/1", cnt16, busy16);
      end
      @(posedge clk); #1;
      checks++;
      if ({crc16, cnt16, busy16, ok16, err16} !== {16'hFFFF, 12'd0, 3'b000}) begin
         failures++;
         $display("FAIL clear crc=%h cnt=%0d busy=%b ok=%b err=%b expected FFFF/0/0/0/0",
                  crc16, cnt16, busy16, ok16, err16);
      end
      idle(3);
      checks++;
      if (obs16.size() != 0) begin
         failures++;
         $display("FAIL clear_no_done pulses=%0d expected 0", obs16.size());
      end
   endtask

   task automatic test_crc5();
      res_t e, o; bit got;
      logic [4:0] f;
      idle(2); obs5.delete(); dbl5 = 0;
      pkt.delete(); add_bits(32'h5A3, 11);
      f = ref_crc5(); add_bits({27'h0, f}, 5);
      sb5.push_back('{ok: 1'b1, err: 1'b0, cnt: 12'd16, crc: 16'h000C, chk: 1'b1});
      send(0, 1'b1); idle(3);
      pop5(e, o, got);
      checks++;
      if (!got || o.ok !== e.ok || o.err !== e.err || o.cnt !== e.cnt || (e.chk && o.crc !== e.crc)) begin
         failures++;
         $display("FAIL crc5_token got=%b ok=%b err=%b cnt=%0d crc=%h expected ok=%b err=%b cnt=%0d crc=%h",
                  got, o.ok, o.err, o.cnt, o.crc, e.ok, e.err, e.cnt, e.crc);
      end
      // 1,0,1 from 5'h1F steps to 1E, 19, 12
      pkt.delete(); add_bits(32'h5, 3);
      sb5.push_back('{ok: 1'b0, err: 1'b1, cnt: 12'd3, crc: 16'h0012, chk: 1'b1});
      send(0, 1'b1); idle(3);
      pop5(e, o, got);
      checks++;
      if (!got || o.ok !== e.ok || o.err !== e.err || o.cnt !== e.cnt || (e.chk && o.crc !== e.crc)) begin
         failures++;
         $display("FAIL crc5_short got=%b ok=%b err=%b cnt=%0d crc=%h expected ok=%b err=%b cnt=%0d crc=%h",
                  got, o.ok, o.err, o.cnt, o.crc, e.ok, e.err, e.cnt, e.crc);
      end
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0; eop = 1'b1;
      sb5.push_back('{ok: 1'b0, err: 1'b1, cnt: 12'd0, crc: 16'h001F, chk: 1'b1});
      idle(3);
      pop5(e, o, got);
      checks++;
      if (!got || o.ok !== e.ok || o.err !== e.err || o.cnt !== e.cnt || (e.chk && o.crc !== e.crc)) begin
         failures++;
         $display("FAIL crc5_empty got=%b ok=%b err=%b cnt=%0d crc=%h expected ok=%b err=%b cnt=%0d crc=%h",
                  got, o.ok, o.err, o.cnt, o.crc, e.ok, e.err, e.cnt, e.crc);
      end
      checks++;
      if (dbl5 != 0 || obs5.size() != 0) begin
         failures++;
         $display("FAIL crc5_pulses long=%0d extra=%0d expected 0/0", dbl5, obs5.size());
      end
   endtask

   initial begin
      test_reset();
      test_zero_len();
      test_corrupt();
      test_gapped();
      test_back_to_back();
      test_clear();
      test_crc5();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
